var_delay: RTL and testbench
============================

VAR_DELAY -- requirements
Module: var_delay

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per channel sample.
REQ-002 Parameter NUM_CH, default 1: number of parallel channels sharing one delay setting.
REQ-003 Parameter MAX_DELAY, default 16: maximum programmable delay in samples and the buffer depth, which SHALL be at least 2.
REQ-004 Parameter DEFAULT_DELAY, default 1: delay after reset, which SHALL be in the range 1..MAX_DELAY.
REQ-005 Derived constant AW = clog2(MAX_DELAY)+1: width of the delay value.
REQ-006 clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 en  in  1  sample strobe; one sample per cycle while high.
REQ-009 cfg_load  in  1  single-cycle request to load delay_cfg.
REQ-010 delay_cfg  in  AW  requested delay in samples.
REQ-011 din  in  NUM_CH*DATA_WIDTH  input samples, with channel 0 in the LSBs.
REQ-012 dout  out  NUM_CH*DATA_WIDTH  delayed samples (registered).
REQ-013 data_valid  out  1  dout holds a genuine delayed sample.
REQ-014 cfg_err  out  1  one-cycle pulse on rejected cfg_load.

Function
REQ-015 Storage SHALL be a circular buffer of MAX_DELAY entries of NUM_CH*DATA_WIDTH bits, addressed by write pointer wr_ptr, which wraps from MAX_DELAY-1 to 0.
REQ-016 On each cycle with en=1, the block SHALL write din to mem[wr_ptr], advance wr_ptr, and register dout <= mem[(wr_ptr - delay) mod MAX_DELAY] using read-before-write semantics.
REQ-017 For sample index k (0-based, counted since the last reset or accepted load), dout after the sample-k edge SHALL equal din of sample k-D, where D is the active delay. This gives a latency of exactly D en-samples.
REQ-018 When D equals MAX_DELAY, the read address SHALL equal wr_ptr, and the old entry SHALL be returned.
REQ-019 With en=0, dout, data_valid, wr_ptr and fill SHALL hold their values.
REQ-020 A fill counter SHALL saturate at MAX_DELAY.
REQ-021 The FSM SHALL have two states. FILL: data_valid=0, and the FSM moves to RUN on the sample edge at which fill reaches D. RUN: data_valid=1 on every sample edge.
REQ-022 data_valid SHALL first rise on the edge of sample k=D.
REQ-023 An accepted cfg_load SHALL meet the condition 1 <= delay_cfg <= MAX_DELAY. On acceptance the block SHALL load the delay register, clear fill, enter FILL, and clear data_valid and dout to 0 on the next edge.
REQ-024 A rejected cfg_load (delay_cfg=0 or delay_cfg>MAX_DELAY) SHALL leave the delay, FSM and data path unchanged and assert cfg_err for exactly one cycle.
REQ-025 When an accepted cfg_load and en=1 occur in the same cycle, that din SHALL be written and counted as sample 0 of the new delay (fill=1), and dout SHALL still be cleared.
REQ-026 Channels SHALL be independent lanes with identical timing, and no data SHALL move between lanes.

Reset
REQ-027 On the rst=0 edge: dout=0, data_valid=0, cfg_err=0, wr_ptr=0, fill=0, FSM=FILL, delay=DEFAULT_DELAY.
REQ-028 Buffer contents SHALL NOT be reset, and data_valid gating SHALL hide stale entries.
REQ-029 Reset SHALL override cfg_load and en in the same cycle.

Configuration
REQ-030 With macro VAR_DELAY_FILL_EN defined, the block SHALL add output fill_level (width AW), equal to the registered fill counter and reset to 0.
REQ-031 With VAR_DELAY_FILL_EN undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package var_delay_pkg SHALL hold the FSM state type (FILL, RUN) and the clog2 helper function.
REQ-033 One sub-module, delay_ram, SHALL implement a simple dual-port memory with synchronous read, read-before-write and a parameterised width and depth. var_delay SHALL instantiate it once.

Verification
REQ-034 Reset with DEFAULT_DELAY=1, then en=1 continuously with din=1,2,3,... -> dout=0 with data_valid=0 after the first edge, then dout=1,2,3,... with data_valid=1.
REQ-035 Load delay_cfg=5, then feed 20 samples 0x10..0x23 -> data_valid rises on sample 5 with dout=0x10, and dout stays 5 samples behind thereafter.
REQ-036 With MAX_DELAY=16, load delay_cfg=16 and run 40 samples -> correct 16-sample lag across buffer wrap-around.
REQ-037 Load delay_cfg=0 and then delay_cfg=17 -> cfg_err pulses for 1 cycle each, and the active delay and the dout stream are undisturbed.
REQ-038 In RUN at delay 3, toggle en with a random 50% duty -> the delay counts samples, not cycles, and outputs hold while en=0.
REQ-039 In RUN, assert cfg_load=1 with delay_cfg=2 and en=1 together -> data_valid=0 and dout=0 next edge, and data_valid returns two samples later. Then rst=0 mid-stream -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/var_delay_pkg.sv
// -----------------------------------------------------------------------------
// var_delay_pkg
// Shared definitions for the variable delay line:
//   state_t : control FSM states (FILL while the buffer primes, RUN once
//             every output is a genuine delayed sample)
//   clog2   : ceiling log2, usable in parameter expressions
// -----------------------------------------------------------------------------
package var_delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// -----------------------------------------------------------------------------
// delay_ram
// Simple dual-port memory, one write port and one registered read port.
// A read and a write to the same address in the same cycle return the old
// contents (read-before-write). Contents and read register are not reset,
// so the array maps onto block RAM.
// Ports:
//   clk        clock, rising edge
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe; o_rd_data holds while low
//   i_rd_addr  read address
//   o_rd_data  registered read data
// -----------------------------------------------------------------------------
module delay_ram
  import var_delay_pkg::*;
#(
  parameter int    WIDTH  = 32,
  parameter int    DEPTH  = 16,
  localparam int   ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Both ports update with non-blocking assignments, so a colliding read
  // sees the value from before this edge's write.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/var_delay.sv
// -----------------------------------------------------------------------------
// var_delay
// Programmable sample delay line for NUM_CH parallel lanes sharing one delay
// setting. Samples are written to a circular buffer on every en cycle and
// read back D samples later; data_valid marks outputs that are genuine
// delayed samples and zeroes dout otherwise, hiding stale buffer contents.
// Optional feature macro: VAR_DELAY_FILL_EN adds the fill_level output.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   en          sample strobe
//   cfg_load    request to load delay_cfg
//   delay_cfg   requested delay, valid range 1..MAX_DELAY
//   din         input samples, channel 0 in the LSBs
//   dout        delayed samples, zero while data_valid is low
//   data_valid  dout holds a genuine delayed sample
//   cfg_err     one-cycle pulse on a rejected cfg_load
//   fill_level  (VAR_DELAY_FILL_EN only) registered fill counter
// -----------------------------------------------------------------------------
module var_delay
  import var_delay_pkg::*;
#(
  parameter int  DATA_WIDTH    = 32,
  parameter int  NUM_CH        = 1,
  parameter int  MAX_DELAY     = 16,
  parameter int  DEFAULT_DELAY = 1,
  localparam int AW            = clog2(MAX_DELAY) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         cfg_load,
  input  logic [AW-1:0]                delay_cfg,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic                         data_valid,
  output logic                         cfg_err
`ifdef VAR_DELAY_FILL_EN
  ,
  output logic [AW-1:0]                fill_level
`endif
);

  localparam int            PW       = AW - 1;
  localparam int            DW       = NUM_CH * DATA_WIDTH;
  localparam logic [AW-1:0] MAX_D    = AW'(MAX_DELAY);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_DELAY - 1);

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_delay, w_delay_next;
  logic [AW-1:0] r_fill, w_fill_next, w_fill_inc;
  logic [PW-1:0] r_wr_ptr, w_ptr_next;
  logic          r_valid, w_valid_next;
  logic          r_cfg_err, w_cfg_err_next;
  logic          w_cfg_ok, w_accept;
  logic [AW-1:0] w_ptr_ext, w_rd_full;
  logic [PW-1:0] w_rd_addr;
  logic [DW-1:0] w_ram_q;
  logic          w_wr_en;

  // (wr_ptr - delay) mod MAX_DELAY; the operands fit in AW bits because
  // wr_ptr + MAX_DELAY < 2*MAX_DELAY. delay == MAX_DELAY lands on wr_ptr
  // itself, which the read-before-write RAM resolves to the oldest entry.
  always_comb begin
    w_ptr_ext = {1'b0, r_wr_ptr};
    if (w_ptr_ext >= r_delay) begin
      w_rd_full = w_ptr_ext - r_delay;
    end else begin
      w_rd_full = w_ptr_ext + MAX_D - r_delay;
    end
    w_rd_addr = w_rd_full[PW-1:0];
  end

  always_comb begin
    w_cfg_ok       = (delay_cfg != '0) && (delay_cfg <= MAX_D);
    w_accept       = cfg_load && w_cfg_ok;
    w_cfg_err_next = cfg_load && !w_cfg_ok;
    w_state_next   = r_state;
    w_delay_next   = r_delay;
    w_fill_next    = r_fill;
    w_ptr_next     = r_wr_ptr;
    w_valid_next   = r_valid;
    w_fill_inc     = (r_fill == MAX_D) ? MAX_D : r_fill + 1'b1;

    if (en) begin
      w_ptr_next = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    end

    if (w_accept) begin
      // A sample arriving with the load is sample 0 of the new delay, so a
      // delay of 1 is already primed by it.
      w_delay_next = delay_cfg;
      w_valid_next = 1'b0;
      w_fill_next  = en ? AW'(1) : '0;
      w_state_next = (en && delay_cfg == AW'(1)) ? RUN : FILL;
    end else if (en) begin
      w_fill_next = w_fill_inc;
      case (r_state)
        FILL: begin
          w_valid_next = 1'b0;
          if (w_fill_inc >= r_delay) begin
            w_state_next = RUN;
          end
        end
        RUN: begin
          w_valid_next = 1'b1;
        end
        default: begin
          w_state_next = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= FILL;
      r_delay   <= AW'(DEFAULT_DELAY);
      r_fill    <= '0;
      r_wr_ptr  <= '0;
      r_valid   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_delay   <= w_delay_next;
      r_fill    <= w_fill_next;
      r_wr_ptr  <= w_ptr_next;
      r_valid   <= w_valid_next;
      r_cfg_err <= w_cfg_err_next;
    end
  end

  // Reset suppresses buffer writes so a sample presented during reset never
  // enters the line.
  assign w_wr_en = en && rst;

  delay_ram #(
    .WIDTH (DW),
    .DEPTH (MAX_DELAY)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_en   (en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // Each lane is gated by the registered valid flag; lanes never mix.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign dout[gi*DATA_WIDTH +: DATA_WIDTH] =
        r_valid ? w_ram_q[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  assign data_valid = r_valid;
  assign cfg_err    = r_cfg_err;

`ifdef VAR_DELAY_FILL_EN
  assign fill_level = r_fill;
`endif

endmodule

// File: tb/tb_var_delay.sv
module tb_var_delay;

  localparam int DW   = 16;
  localparam int NCH  = 2;
  localparam int MAXD = 16;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          cfg_load = 1'b0;
  logic [AW-1:0] delay_cfg = '0;
  logic [31:0]   din = '0;
  logic [31:0]   dout;
  logic          data_valid;
  logic          cfg_err;
`ifdef VAR_DELAY_FILL_EN
  logic [AW-1:0] fill_level;
`endif

  var_delay #(
    .DATA_WIDTH    (DW),
    .NUM_CH        (NCH),
    .MAX_DELAY     (MAXD),
    .DEFAULT_DELAY (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_load   (cfg_load),
    .delay_cfg  (delay_cfg),
    .din        (din),
    .dout       (dout),
    .data_valid (data_valid),
    .cfg_err    (cfg_err)
`ifdef VAR_DELAY_FILL_EN
    ,
    .fill_level (fill_level)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Samples fed since the last reset / accepted load, and the active delay.
  logic [15:0] hist [0:255];
  int          count = 0;
  int          cur_d = 1;

  // Lane 1 carries a scrambled copy of lane 0 so lane crossing is visible.
  function automatic logic [31:0] pack(input logic [15:0] v);
    return {v ^ 16'hA5A5, v};
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Hand-computed expectation: valid flag and lane-0 value.
  task automatic check_exp(input string tag, input logic ev, input logic [15:0] ed);
    check1({tag, ".valid"}, data_valid, ev);
    check32({tag, ".dout"}, dout, ev ? pack(ed) : 32'h0);
  endtask

  // Expectation from the sample history: after n samples at delay D the
  // output is sample n-1-D once n > D.
  task automatic check_model(input string tag);
    logic        ev;
    logic [31:0] ed;
    ev = (count > cur_d);
    ed = ev ? pack(hist[count - 1 - cur_d]) : 32'h0;
    check1({tag, ".valid"}, data_valid, ev);
    check32({tag, ".dout"}, dout, ed);
`ifdef VAR_DELAY_FILL_EN
    check32({tag, ".fill"}, {27'h0, fill_level}, (count > MAXD) ? MAXD : count);
`endif
  endtask

  // One clock with the given inputs; checks cfg_err and updates the model.
  task automatic cycle(input logic e, input logic [15:0] v, input logic ld, input logic [AW-1:0] cfg);
    logic accept;
    en        = e;
    din       = pack(v);
    cfg_load  = ld;
    delay_cfg = cfg;
    @(posedge clk);
    #1;
    accept = ld && (cfg >= 1) && (cfg <= MAXD);
    if (accept) begin
      cur_d = int'(cfg);
      count = 0;
    end
    if (e) begin
      hist[count] = v;
      count++;
    end
    cfg_load = 1'b0;
    en       = 1'b0;
    check1($sformatf("cfg_err v=%h", v), cfg_err, ld && !accept);
    $display("txn en=%b din=%h load=%b cfg=%0d -> dout=%h valid=%b err=%b",
             e, v, ld, cfg, dout, data_valid, cfg_err);
  endtask

  initial begin
    // Reset overrides en and cfg_load.
    rst = 1'b0; en = 1'b1; cfg_load = 1'b1; delay_cfg = 5'd0; din = pack(16'hDEAD);
    repeat (2) @(posedge clk);
    #1;
    check32("reset.dout", dout, 32'h0);
    check1("reset.valid", data_valid, 1'b0);
    check1("reset.cfg_err", cfg_err, 1'b0);
`ifdef VAR_DELAY_FILL_EN
    check32("reset.fill", {27'h0, fill_level}, 32'h0);
`endif
    en = 1'b0; cfg_load = 1'b0;
    rst = 1'b1;
    count = 0; cur_d = 1;

    // Default delay 1: din 1,2,3.. -> dout 0 then 1,2,3..
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'(i + 1), 1'b0, 5'd0);
      check_exp($sformatf("d1.s%0d", i), i >= 1, 16'(i));
    end

    // Load delay 5, then 0x10..0x23.
    cycle(1'b0, 16'h0, 1'b1, 5'd5);
    check_exp("load5", 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'(16'h10 + i), 1'b0, 5'd0);
      check_exp($sformatf("d5.s%0d", i), i >= 5, 16'(16'h10 + i - 5));
    end

    // Rejected loads with en high: stream continues at delay 5.
    cycle(1'b1, 16'h24, 1'b1, 5'd0);
    check_model("rej0");
    cycle(1'b1, 16'h25, 1'b0, 5'd0);
    check_model("rej0.after");
    cycle(1'b1, 16'h26, 1'b1, 5'd17);
    check_model("rej17");
    cycle(1'b1, 16'h27, 1'b0, 5'd0);
    check_exp("rej17.after", 1'b1, 16'h22);

    // Maximum delay across buffer wrap-around.
    cycle(1'b0, 16'h0, 1'b1, 5'd16);
    check_exp("load16", 1'b0, 16'h0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 16'(16'h100 + i), 1'b0, 5'd0);
      check_exp($sformatf("d16.s%0d", i), i >= 16, 16'(16'h100 + i - 16));
    end

    // Delay 3 with en toggling: delay counts samples, outputs hold when idle.
    cycle(1'b0, 16'h0, 1'b1, 5'd3);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'(16'h200 + i), 1'b0, 5'd0);
      check_model($sformatf("d3.s%0d", i));
    end
    for (int j = 0; j < 40; j++) begin
      cycle(1'($urandom_range(0, 1)), 16'(16'h280 + j), 1'b0, 5'd0);
      check_model($sformatf("d3.rnd%0d", j));
    end

    // Load delay 2 together with a sample.
    cycle(1'b1, 16'h300, 1'b1, 5'd2);
    check_exp("ld2en", 1'b0, 16'h0);
    cycle(1'b1, 16'h301, 1'b0, 5'd0);
    check_exp("d2.s1", 1'b0, 16'h0);
    cycle(1'b1, 16'h302, 1'b0, 5'd0);
    check_exp("d2.s2", 1'b1, 16'h300);
    cycle(1'b1, 16'h303, 1'b0, 5'd0);
    check_exp("d2.s3", 1'b1, 16'h301);

    // Mid-stream reset.
    rst = 1'b0; en = 1'b1; cfg_load = 1'b1; delay_cfg = 5'd20; din = pack(16'h3FF);
    @(posedge clk);
    #1;
    check32("midrst.dout", dout, 32'h0);
    check1("midrst.valid", data_valid, 1'b0);
    check1("midrst.cfg_err", cfg_err, 1'b0);
    $display("txn rst=0 -> dout=%h valid=%b err=%b", dout, data_valid, cfg_err);
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    count = 0; cur_d = 1;

    // Default delay restored after reset.
    cycle(1'b1, 16'h400, 1'b0, 5'd0);
    check_exp("post.s0", 1'b0, 16'h0);
    cycle(1'b1, 16'h401, 1'b0, 5'd0);
    check_exp("post.s1", 1'b1, 16'h400);
    cycle(1'b1, 16'h402, 1'b0, 5'd0);
    check_model("post.s2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
